// File: rtl/pit_count_chan_if.sv
// pit_count_chan_if: control/data bundle between the 8253 bus/control-word
// logic (master) and one timer channel (slave).
interface pit_count_chan_if #(
   parameter int DIGITS = 4
) ();
   localparam int W = 4 * DIGITS;

   logic         load;      // one-cycle (re)load strobe
   logic [W-1:0] load_val;  // initial/reload count, 0 = full range
   logic         bcd_in;    // 1 = BCD counting, sampled on load
   logic [1:0]   mode_in;   // output waveform mode, sampled on load
   logic         gate;      // count enable / retrigger
   logic         en;        // divided timer tick qualifier
   logic [W-1:0] count;     // current counter value
   logic         out;       // channel output waveform
   logic         tc;        // one-cycle terminal-event pulse

   modport master (
      output load, load_val, bcd_in, mode_in, gate, en,
      input  count, out, tc
   );

   modport slave (
      input  load, load_val, bcd_in, mode_in, gate, en,
      output count, out, tc
   );
endinterface

// File: rtl/pit_count_chan.sv
// pit_count_chan: one 8253-class timer channel. A DIGITS-nibble down counter
// with per-load binary/BCD selection, gate control and three output modes:
// interrupt on terminal count (0/1), rate generator (2), square wave (3).
module pit_count_chan #(
   parameter int DIGITS = 4
) (
   input  logic            clk,
   input  logic            rst,
   pit_count_chan_if.slave bus
);
   localparam int W = 4 * DIGITS;
   localparam logic [W-1:0] ONE = W'(1);
   localparam logic [W-1:0] TWO = W'(2);

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } state_e;

   typedef enum logic [1:0] {
      MODE_TC0    = 2'd0,
      MODE_TC1    = 2'd1,
      MODE_RATE   = 2'd2,
      MODE_SQUARE = 2'd3
   } mode_e;

   // Digitwise BCD subtract of 1 or 2 with a rippling borrow. A borrowing
   // digit wraps through ten; digits A-F are not corrected (A-1 = 9).
   function automatic logic [W-1:0] bcd_sub(input logic [W-1:0] v,
                                            input logic [1:0]   amt);
      logic [W-1:0] r;
      logic [4:0]   need;
      logic [4:0]   d;
      r    = '0;
      need = {3'b000, amt};
      for (int i = 0; i < DIGITS; i++) begin
         d = {1'b0, v[4*i +: 4]};
         if (d >= need) begin
            r[4*i +: 4] = 4'(d - need);
            need        = 5'd0;
         end else begin
            r[4*i +: 4] = 4'(d + 5'd10 - need);
            need        = 5'd1;
         end
      end
      return r;
   endfunction

   // Decrement by 1 or 2 in the selected number system (binary wraps mod 2^W).
   function automatic logic [W-1:0] count_sub(input logic [W-1:0] v,
                                              input logic [1:0]   amt,
                                              input logic         bcd);
      if (bcd) begin
         return bcd_sub(v, amt);
      end
      return v - {{(W-2){1'b0}}, amt};
   endfunction

   state_e       state_r,  state_nxt;
   mode_e        mode_r,   mode_nxt;
   logic [W-1:0] count_r,  count_nxt;
   logic [W-1:0] reload_r, reload_nxt;
   logic         bcd_r,    bcd_nxt;
   logic         out_r,    out_nxt;
   logic         tc_r,     tc_nxt;
   logic         gate_d;
   logic         gate_rise;
   logic         tick;

   // Next-state and datapath: load first, then per-mode counting in RUN.
   always_comb begin
      // NOTE: every signal driven here gets a default first so that no path
      // through the if/case tree leaves one unassigned and infers a latch.
      state_nxt  = state_r;
      mode_nxt   = mode_r;
      count_nxt  = count_r;
      reload_nxt = reload_r;
      bcd_nxt    = bcd_r;
      out_nxt    = out_r;
      tc_nxt     = 1'b0;
      gate_rise  = bus.gate & ~gate_d;
      tick       = (state_r == ST_RUN) & bus.gate & bus.en & ~bus.load;

      if (bus.load) begin
         // A load wins over any same-cycle tick or gate edge.
         state_nxt  = ST_RUN;
         mode_nxt   = mode_e'(bus.mode_in);
         reload_nxt = bus.load_val;
         bcd_nxt    = bus.bcd_in;
         count_nxt  = (mode_nxt == MODE_SQUARE) ? (bus.load_val & ~ONE) : bus.load_val;
         out_nxt    = (mode_nxt == MODE_RATE) || (mode_nxt == MODE_SQUARE);
      end else if (state_r == ST_IDLE) begin
         out_nxt = 1'b1;
      end else begin
         case (mode_r)
            MODE_TC0, MODE_TC1: begin
               // One-shot: out rises on 1->0 and stays high; counter wraps on.
               if (tick) begin
                  count_nxt = count_sub(count_r, 2'd1, bcd_r);
                  if (count_r == ONE) begin
                     out_nxt = 1'b1;
                     tc_nxt  = 1'b1;
                  end
               end
            end
            MODE_RATE: begin
               if (!bus.gate) begin
                  out_nxt = 1'b1;
               end else if (gate_rise) begin
                  count_nxt = reload_r;
                  out_nxt   = 1'b1;
               end else begin
                  if (tick) begin
                     if (count_r == ONE) begin
                        count_nxt = reload_r;
                        tc_nxt    = 1'b1;
                     end else begin
                        count_nxt = count_sub(count_r, 2'd1, bcd_r);
                     end
                  end
                  // Output is low for exactly the count==1 state.
                  out_nxt = (count_nxt != ONE);
               end
            end
            MODE_SQUARE: begin
               // Counting by two from an even reload; each half period toggles out.
               if (!bus.gate) begin
                  out_nxt = 1'b1;
               end else if (gate_rise) begin
                  count_nxt = reload_r & ~ONE;
                  out_nxt   = 1'b1;
               end else if (tick) begin
                  if (count_r == TWO) begin
                     count_nxt = reload_r & ~ONE;
                     out_nxt   = ~out_r;
                     tc_nxt    = 1'b1;
                  end else begin
                     count_nxt = count_sub(count_r, 2'd2, bcd_r);
                  end
               end
            end
            default: begin
               count_nxt = count_r;
            end
         endcase
      end
   end

   // Channel state register; reset returns to IDLE with the output high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         mode_r   <= MODE_TC0;
         count_r  <= '0;
         reload_r <= '0;
         bcd_r    <= 1'b0;
         gate_d   <= 1'b0;
         out_r    <= 1'b1;
         tc_r     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values computed above, independent of statement order.
         state_r  <= state_nxt;
         mode_r   <= mode_nxt;
         count_r  <= count_nxt;
         reload_r <= reload_nxt;
         bcd_r    <= bcd_nxt;
         gate_d   <= bus.gate;
         out_r    <= out_nxt;
         tc_r     <= tc_nxt;
      end
   end

   assign bus.count = count_r;
   assign bus.out   = out_r;
   assign bus.tc    = tc_r;

endmodule

// File: tb/tb_pit_count_chan.sv
// tb_pit_count_chan: scoreboard bench for pit_count_chan. Stimulus drives the
// channel on the falling edge and queues the reference model's expected
// outputs; a monitor pops and compares just after each rising edge.
module tb_pit_count_chan;
   localparam int DIGITS = 4;
   localparam int W      = 4 * DIGITS;

   logic clk;
   logic rst;
   logic rst_req;

   pit_count_chan_if #(.DIGITS(DIGITS)) bus ();

   pit_count_chan #(.DIGITS(DIGITS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] count;
      logic         out;
      logic         tc;
      int           step;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   step   = 0;
   event chk_now;

   // Reference model state
   logic         m_run;
   logic [W-1:0] m_count;
   logic [W-1:0] m_reload;
   logic [1:0]   m_mode;
   logic         m_bcd;
   logic         m_gate_d;
   logic         m_out;
   logic         m_tc;

   task automatic check(input string name, input int stp,
                        input logic [W-1:0] got, input logic [W-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, stp, got, want);
      end
   endtask

   function automatic int dec_range();
      int r = 1;
      for (int i = 0; i < DIGITS; i++) r = r * 10;
      return r;
   endfunction

   function automatic int from_bcd(input logic [W-1:0] v);
      int r = 0;
      int p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         r = r + int'(v[4*i +: 4]) * p;
         p = p * 10;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] to_bcd(input int n);
      logic [W-1:0] r = '0;
      int           x = n;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Decimal arithmetic when a borrow leaves the low digit, plain subtraction
   // otherwise (which also covers uncorrected A-F low digits).
   function automatic logic [W-1:0] m_dec(input logic [W-1:0] v, input int amt,
                                          input logic bcd);
      int dv;
      if (!bcd || int'(v[3:0]) >= amt) return v - W'(amt);
      dv = from_bcd(v) - amt;
      if (dv < 0) dv = dv + dec_range();
      return to_bcd(dv);
   endfunction

   task automatic model_reset();
      m_run = 1'b0; m_count = '0; m_reload = '0; m_mode = 2'd0;
      m_bcd = 1'b0; m_gate_d = 1'b0; m_out = 1'b1; m_tc = 1'b0;
   endtask

   task automatic model_step(input logic ld, input logic [W-1:0] val, input logic b,
                             input logic [1:0] md, input logic g, input logic e);
      logic rise;
      rise = g && !m_gate_d;
      m_tc = 1'b0;
      if (ld) begin
         m_run    = 1'b1;
         m_reload = val;
         m_mode   = md;
         m_bcd    = b;
         m_count  = (md == 2'd3) ? (val & ~W'(1)) : val;
         m_out    = (md >= 2'd2);
      end else if (!m_run) begin
         m_out = 1'b1;
      end else if (m_mode < 2'd2) begin
         if (g && e) begin
            if (m_count == W'(1)) begin
               m_out = 1'b1;
               m_tc  = 1'b1;
            end
            m_count = m_dec(m_count, 1, m_bcd);
         end
      end else if (!g) begin
         m_out = 1'b1;
      end else if (rise) begin
         m_count = (m_mode == 2'd3) ? (m_reload & ~W'(1)) : m_reload;
         m_out   = 1'b1;
      end else if (m_mode == 2'd2) begin
         if (e) begin
            if (m_count == W'(1)) begin
               m_count = m_reload;
               m_tc    = 1'b1;
            end else begin
               m_count = m_dec(m_count, 1, m_bcd);
            end
         end
         m_out = (m_count != W'(1));
      end else if (e) begin
         if (m_count == W'(2)) begin
            m_count = m_reload & ~W'(1);
            m_out   = !m_out;
            m_tc    = 1'b1;
         end else begin
            m_count = m_dec(m_count, 2, m_bcd);
         end
      end
      m_gate_d = g;
   endtask

   task automatic push_exp();
      exp_t x;
      x.count = m_count;
      x.out   = m_out;
      x.tc    = m_tc;
      x.step  = step;
      step++;
      sb_q.push_back(x);
   endtask

   // One clock of stimulus: drive on the falling edge, queue the expected result.
   task automatic cycle(input logic ld, input logic [W-1:0] val, input logic b,
                        input logic [1:0] md, input logic g, input logic e);
      @(negedge clk);
      rst          = rst_req;
      bus.load     = ld;
      bus.load_val = val;
      bus.bcd_in   = b;
      bus.mode_in  = md;
      bus.gate     = g;
      bus.en       = e;
      if (rst) model_reset();
      else     model_step(ld, val, b, md, g, e);
      push_exp();
   endtask

   task automatic run(input int n, input logic g, input logic e);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 2'd0, g, e);
   endtask

   task automatic ld(input logic [W-1:0] val, input logic b, input logic [1:0] md);
      cycle(1'b1, val, b, md, 1'b1, 1'b1);
   endtask

   // Assert reset between edges and check its effect right away.
   task automatic reset_now();
      @(negedge clk);
      #2;
      rst_req = 1'b1;
      rst     = 1'b1;
      model_reset();
      push_exp();
      -> chk_now;
      push_exp();
   endtask

   // Monitor: compare every presented output against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or chk_now);
         #1;
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("count", e.step, bus.count, e.count);
            check("out",   e.step, W'(bus.out), W'(e.out));
            check("tc",    e.step, W'(bus.tc),  W'(e.tc));
         end
      end
   end

   // Stimulus: directed scenarios followed by randomized traffic.
   initial begin
      logic         r_ld;
      logic [W-1:0] r_val;
      logic         r_b;
      logic [1:0]   r_md;
      logic         r_g;
      logic         r_e;
      int           n;

      rst = 1'b1; rst_req = 1'b1;
      bus.load = 1'b0; bus.load_val = '0; bus.bcd_in = 1'b0;
      bus.mode_in = 2'd0; bus.gate = 1'b0; bus.en = 1'b0;
      model_reset();

      run(3, 1'b1, 1'b1);
      rst_req = 1'b0;
      run(2, 1'b1, 1'b1);

      // Mode 0 binary through terminal count and wrap
      ld(16'h0003, 1'b0, 2'd0);
      run(6, 1'b1, 1'b1);

      // Mode 0 BCD borrow, full range, and non-BCD low digit
      ld(16'h0100, 1'b1, 2'd0); run(1, 1'b1, 1'b1);
      ld(16'h0000, 1'b1, 2'd0); run(1, 1'b1, 1'b1);
      ld(16'h000A, 1'b1, 2'd0); run(1, 1'b1, 1'b1);

      // Mode 2 rate generator with a gate-low pause and retrigger
      ld(16'h0004, 1'b0, 2'd2);
      run(9, 1'b1, 1'b1);
      run(2, 1'b0, 1'b1);
      run(6, 1'b1, 1'b1);

      // Mode 3 square wave, odd reload, gate fall and rise
      ld(16'h0006, 1'b0, 2'd3);
      run(14, 1'b1, 1'b1);
      ld(16'h0007, 1'b0, 2'd3);
      run(8, 1'b1, 1'b1);
      run(2, 1'b0, 1'b1);
      run(4, 1'b1, 1'b1);

      // Load coinciding with a tick, then en gaps
      ld(16'h0008, 1'b0, 2'd0);
      run(3, 1'b1, 1'b1);
      ld(16'h0042, 1'b0, 2'd0);
      for (int i = 0; i < 8; i++) run(1, 1'b1, 1'(i % 2));

      // Reset in the middle of a count
      ld(16'h1234, 1'b0, 2'd0);
      run(3, 1'b1, 1'b1);
      reset_now();
      run(3, 1'b1, 1'b1);
      rst_req = 1'b0;
      run(4, 1'b1, 1'b1);

      // Randomized traffic
      r_g = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         r_ld = ($urandom_range(0, 39) == 0);
         r_b  = 1'($urandom_range(0, 1));
         r_md = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 2))
            0:       n = int'($urandom_range(0, 12));
            1:       n = int'($urandom_range(0, 99));
            default: n = int'($urandom_range(0, r_b ? 9999 : 65535));
         endcase
         r_val = r_b ? to_bcd(n) : W'(n);
         if ($urandom_range(0, 15) == 0) r_g = ~r_g;
         r_e = ($urandom_range(0, 3) != 0);
         cycle(r_ld, r_val, r_b, r_md, r_g, r_e);
      end

      @(posedge clk);
      #3;
      check("queue_drain", step, W'(sb_q.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pit_count_chan.md
# pit_count_chan

Parametrised down-counter channel for the 8253-class interval timer: a DIGITS-nibble counter with per-load binary/BCD selection, gate control, and three output waveform modes (interrupt-on-terminal-count, rate generator, square wave). It generalises the single-digit BCD/binary down counter to a full counter width with reload, gating and output generation. Three instances sit behind the 8253 bus/control-word logic, one per timer channel.

## Interface
- DIGITS, 4, number of 4-bit digits; counter width W = 4*DIGITS
- clk  input  1  channel clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- load  input  1  one-cycle strobe: capture load_val, bcd_in, mode_in and (re)start counting
- load_val  input  W  initial/reload count; 0 means full range (2^W binary, 10^DIGITS BCD)
- bcd_in  input  1  1 = BCD counting, 0 = binary; sampled on load
- mode_in  input  2  0 = interrupt on TC, 1 = same as 0, 2 = rate generator, 3 = square wave; sampled on load
- gate  input  1  count enable / retrigger
- en  input  1  count tick qualifier (divided timer clock); decrement only when en=1
- count  output  W  current counter value (registered)
- out  output  1  channel output waveform (registered)
- tc  output  1  one-cycle terminal-event pulse (registered)

## Operation
- State: IDLE (nothing loaded), RUN. Stored: count, reload (load_val), mode_r, bcd_r, gate_d (previous gate), out, tc.
- Reset: count=0, reload=0, mode_r=0, bcd_r=0, gate_d=0, out=1, tc=0, state IDLE.
- IDLE: no decrement; out=1. load -> RUN.
- load (any state): count<=load_val (mode 3: load_val & ~1), store reload/mode/bcd; out<=0 for modes 0/1, out<=1 for modes 2/3; tc<=0. load overrides a same-cycle tick and same-cycle gate edge.
- Tick = state RUN, gate=1, en=1, no load.
- Mode 0/1: tick decrements by 1. Transition 1->0 sets out=1, pulses tc. Counting continues; 0 wraps to all-F (binary) or all-9 (BCD); out stays 1 until next load. gate=0 pauses, out unaffected.
- Mode 2: tick with count==1 reloads count<=reload and pulses tc; otherwise decrement by 1. out=0 exactly while count==1 in RUN, else 1.
- Mode 3: tick with count==2 reloads count<=reload&~1, toggles out, pulses tc; otherwise decrement by 2. Odd reload values count as N-1; reload of 1 or 0 is full range.
- Modes 2/3: gate=0 forces out=1 next cycle and pauses count; gate rising edge (gate=1, gate_d=0) reloads count from reload, out=1, no tc.
- BCD arithmetic: digitwise subtract with borrow ripple; borrowing digit 0 becomes 9. Non-BCD digits (A-F) decrement normally (A->9) and are not corrected. Subtract-by-2 uses the same borrow chain.
- Binary arithmetic: modulo 2^W.

## Timing
- All outputs registered; count/out/tc change only on clk rising edge or rst.
- load at edge k -> count=load_val visible after edge k.
- Tick at edge k -> new count, out and tc visible after edge k; tc high for exactly one cycle per terminal event, even when en stays high.
- gate sampled on clk; edge detect adds no extra latency: rise seen at edge k reloads at edge k.
- rst mid-count: immediate return to reset values; no tc emitted.

## Test plan
- Reset: assert rst mid-count from 0x1234 -> count=0x0000, out=1, tc=0 immediately; no ticks counted while rst high.
- Mode 0 binary, DIGITS=4, load 0x0003, gate=1, en=1 -> count 3,2,1,0,FFFF; out 0 until count=0 then 1 permanently; tc high only the cycle count becomes 0.
- Mode 0 BCD: load 0x0100, one tick -> 0x0099; load 0x0000, one tick -> 0x9999; load 0x000A, one tick -> 0x0009.
- Mode 2, load 4 -> count 4,3,2,1,4,3...; out=0 only while count=1; tc pulse on each reload; gate low 2 cycles holds count, out=1.
- Mode 3, load 6 -> count 6,4,2,6,4,2...; out 1 for 3 ticks, 0 for 3 ticks; load 7 behaves as 6; gate fall -> out=1, gate rise -> count=6.
- Load coincident with tick at count 5 (mode 0) -> count=load_val, no decrement, tc=0; en=0 cycles interleaved -> count holds.
